// File: rtl/store_buffer.sv
// Post-commit store buffer: FIFO of retired doubleword stores drained to memory over valid/ready,
// with youngest-match load lookup. Define STORE_BUF_FWD_EN to forward data; otherwise matching loads stall.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_stall,
  output logic                     mem_wr_valid,
  output logic [ADDR_W-1:0]        mem_wr_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  input  logic                     mem_wr_ready,
  input  logic                     fence_req,
  output logic                     fence_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_FENCE  = 2'd2;
  localparam logic [1:0] S_FENCED = 2'd3;

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid never depends on ready, and offered write data holds until accepted.

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic              full, empty, push, pop;
  logic              match_any;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full && !fence_req;
  assign push     = st_valid && st_ready;
  assign mem_wr_valid = !empty;
  assign pop      = mem_wr_valid && mem_wr_ready;

  assign mem_wr_addr = addr_q[head_q];
  assign mem_wr_data = data_q[head_q];

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // The state follows the live fence level and the post-edge occupancy.
  always_comb begin
    state_d = state_q;
    if (fence_req) state_d = (count_d == '0) ? S_FENCED : S_FENCE;
    else           state_d = (count_d == '0) ? S_IDLE   : S_DRAIN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [DATA_W-1:0] fwd_data;
`endif

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    match_any = 1'b0;
`ifdef STORE_BUF_FWD_EN
    fwd_data  = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx] == ld_addr)) begin
        match_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
        fwd_data  = data_q[idx];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign ld_hit   = ld_valid && match_any;
  assign ld_data  = ld_hit ? fwd_data : '0;
  assign ld_stall = 1'b0;
`else
  assign ld_hit   = 1'b0;
  assign ld_data  = '0;
  assign ld_stall = ld_valid && match_any;
`endif

  assign fence_done = (state_q == S_FENCED);
  assign count      = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then random traffic,
// every cycle compared against a queue-based model of the buffer contents.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic        ld_hit;
  logic [63:0] ld_data;
  logic        ld_stall;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_ready;
  logic        fence_req;
  logic        fence_done;
  logic [2:0]  count;
  logic [1:0]  dbg_state;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_stall(ld_stall),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready),
    .fence_req(fence_req), .fence_done(fence_done),
    .count(count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected buffer contents, oldest first
  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  logic        exp_fence_done;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic        m;
    logic [63:0] d;
    logic        e_hit, e_stall;
    logic [63:0] e_data;
    m = 1'b0;
    d = '0;
    foreach (exp_addr_q[i]) if (exp_addr_q[i] == ld_addr) begin m = 1'b1; d = exp_data_q[i]; end
`ifdef STORE_BUF_FWD_EN
    e_hit   = ld_valid && m;
    e_data  = e_hit ? d : 64'h0;
    e_stall = 1'b0;
`else
    e_hit   = 1'b0;
    e_data  = 64'h0;
    e_stall = ld_valid && m;
`endif
    chk({tag, ".count"}, 64'(count), 64'(exp_addr_q.size()));
    chk({tag, ".st_ready"}, 64'(st_ready), 64'((exp_addr_q.size() < DEPTH) && !fence_req));
    chk({tag, ".mem_wr_valid"}, 64'(mem_wr_valid), 64'(exp_addr_q.size() != 0));
    if (exp_addr_q.size() != 0) begin
      chk({tag, ".mem_wr_addr"}, mem_wr_addr, exp_addr_q[0]);
      chk({tag, ".mem_wr_data"}, mem_wr_data, exp_data_q[0]);
    end
    chk({tag, ".ld_hit"}, 64'(ld_hit), 64'(e_hit));
    chk({tag, ".ld_data"}, ld_data, e_data);
    chk({tag, ".ld_stall"}, 64'(ld_stall), 64'(e_stall));
    chk({tag, ".fence_done"}, 64'(fence_done), 64'(exp_fence_done));
  endtask

  task automatic update_model();
    logic push, pop;
    if (!rst_n) begin
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_fence_done = 1'b0;
    end else begin
      push = st_valid && (exp_addr_q.size() < DEPTH) && !fence_req;
      pop  = (exp_addr_q.size() != 0) && mem_wr_ready;
      if (pop) begin
        void'(exp_addr_q.pop_front());
        void'(exp_data_q.pop_front());
      end
      if (push) begin
        exp_addr_q.push_back(st_addr);
        exp_data_q.push_back(st_data);
      end
      exp_fence_done = fence_req && (exp_addr_q.size() == 0);
    end
  endtask

  // driver: inputs already applied; check mid-cycle, then advance one edge
  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_store(input logic v, input logic [63:0] a, input logic [63:0] d);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_wr_ready = 1'b0; fence_req = 1'b0;
    exp_fence_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset_hold");
    rst_n = 1'b1;

    // reset in the middle of a two-entry drain
    set_store(1'b1, 64'h200, 64'h11); step("rst_fill0");
    set_store(1'b1, 64'h208, 64'h22); step("rst_fill1");
    set_store(1'b0, 64'h0, 64'h0); mem_wr_ready = 1'b1;
    step("rst_drain");
    rst_n = 1'b0; step("rst_mid");
    rst_n = 1'b1; step("rst_after");

    // two stores to one address, then a load of it
    mem_wr_ready = 1'b0;
    set_store(1'b1, 64'h100, 64'hAA); step("fwd_st0");
    set_store(1'b1, 64'h100, 64'hBB); step("fwd_st1");
    set_store(1'b0, 64'h0, 64'h0);
    ld_valid = 1'b1; ld_addr = 64'h100;
    step("fwd_ld");
    ld_addr = 64'h108; step("fwd_miss");
    ld_addr = 64'h100; mem_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("fwd_drain%0d", i));
    ld_valid = 1'b0;

    // fill to full with memory stalled; fifth store held
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_store(1'b1, 64'h300 + 64'(8 * i), 64'hC0 + 64'(i));
      step($sformatf("full_st%0d", i));
    end
    set_store(1'b0, 64'h0, 64'h0); mem_wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) step($sformatf("full_drain%0d", i));

    // enqueue and pop together at two entries
    mem_wr_ready = 1'b0;
    set_store(1'b1, 64'h400, 64'h1); step("sim_st0");
    set_store(1'b1, 64'h408, 64'h2); step("sim_st1");
    set_store(1'b1, 64'h410, 64'h3); mem_wr_ready = 1'b1;
    step("sim_both");
    set_store(1'b0, 64'h0, 64'h0);
    for (int i = 0; i < 4; i++) step($sformatf("sim_drain%0d", i));

    // fence with three entries
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 64'h500 + 64'(8 * i), 64'hF0 + 64'(i));
      step($sformatf("fence_st%0d", i));
    end
    set_store(1'b1, 64'h600, 64'hEE); fence_req = 1'b1; mem_wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) step($sformatf("fence_wait%0d", i));
    set_store(1'b0, 64'h0, 64'h0); fence_req = 1'b0;
    step("fence_drop0");
    step("fence_drop1");

    // random traffic over a small address window to provoke matches
    for (int c = 0; c < 800; c++) begin
      set_store($urandom_range(0, 1) == 1, 64'h100 + 64'(8 * $urandom_range(0, 7)),
                {$urandom, $urandom});
      ld_valid     = $urandom_range(0, 1) == 1;
      ld_addr      = 64'h100 + 64'(8 * $urandom_range(0, 7));
      mem_wr_ready = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 15) == 0) fence_req = ~fence_req;
      rst_n = ($urandom_range(0, 199) != 0);
      step($sformatf("rand%0d", c));
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
